// File: rtl/flab_pkg.sv
// Shared constants and types for the FLAB game datapath: field geometry,
// bird columns, field FSM states, LFSR taps and the pipe gap helper.
package flab_pkg;

  localparam int NROWS         = 8;
  localparam int NCOLS         = 8;
  localparam int BIRD_TAIL_COL = 1;
  localparam int BIRD_HEAD_COL = 2;

  // Feedback taps b7, b5, b4, b3 of the 8-bit Fibonacci LFSR
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } fieldState;

  // Gap of gap_h ones starting at row lfsr[1:0]+1; a pipe column is its complement
  function automatic logic [7:0] gap_mask(input logic [1:0] sel, input int gap_h);
    logic [7:0] ones;
    logic [2:0] g;
    ones = 8'((1 << gap_h) - 1);
    g    = {1'b0, sel} + 3'd1;
    return ones << g;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shifting left; steps only when en is high.
module lfsr8
  import flab_pkg::*;
#(
  parameter logic [7:0] seed = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe field for FLAB: spawns gapped pipes, detects bird/pipe
// overlap, counts passed pipes and freezes on crash or boundary game over.
//
// state | meaning
// RUN   | field advances on each cont tick
// STOP  | field frozen after crash or gameOver; only reset leaves it
module pipe_field
  import flab_pkg::*;
#(
  parameter int         SPAWN_GAP = 4,
  parameter int         GAP_H     = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cont,
  input  logic [7:0]  head,
  input  logic [7:0]  tail,
  input  logic        gameOver,
  output logic [63:0] field,
  output logic        crash,
  output logic [7:0]  score,
  output logic        running
);

  localparam logic [3:0] SPAWN_RELOAD = 4'(SPAWN_GAP - 1);

  fieldState  state_q, state_d;
  logic [7:0] col_q [NCOLS];
  logic [7:0] col_d [NCOLS];
  logic [3:0] spawn_cnt_q, spawn_cnt_d;
  logic [7:0] score_q, score_d;
  logic       crash_q, crash_d;
  logic [7:0] lfsr;
  logic       overlap, adv, crash_next;

  lfsr8 #(.seed(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (adv),
    .q     (lfsr)
  );

  assign overlap    = (|(col_q[BIRD_TAIL_COL] & tail)) | (|(col_q[BIRD_HEAD_COL] & head));
  assign adv        = cont & (state_q == RUN) & ~overlap & ~gameOver;
  assign crash_next = overlap & (state_q == RUN);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (crash_next || gameOver) state_d = STOP;
      STOP:    state_d = STOP;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state_q == RUN);
  end

  always_comb begin
    for (int c = 0; c < NCOLS; c++) col_d[c] = col_q[c];
    spawn_cnt_d = spawn_cnt_q;
    score_d     = score_q;
    crash_d     = crash_q | crash_next;
    if (adv) begin
      for (int c = 0; c < NCOLS - 1; c++) col_d[c] = col_q[c + 1];
      if (spawn_cnt_q == 4'd0) begin
        col_d[NCOLS-1] = ~gap_mask(lfsr[1:0], GAP_H);
        spawn_cnt_d    = SPAWN_RELOAD;
      end else begin
        col_d[NCOLS-1] = 8'h00;
        spawn_cnt_d    = spawn_cnt_q - 4'd1;
      end
      // A pipe still in the tail column is about to slide past the bird
      if (col_q[BIRD_TAIL_COL] != 8'h00 && score_q != 8'hFF) score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCOLS; c++) col_q[c] <= 8'h00;
      spawn_cnt_q <= SPAWN_RELOAD;
      score_q     <= 8'h00;
      crash_q     <= 1'b0;
    end else begin
      for (int c = 0; c < NCOLS; c++) col_q[c] <= col_d[c];
      spawn_cnt_q <= spawn_cnt_d;
      score_q     <= score_d;
      crash_q     <= crash_d;
    end
  end

  always_comb begin
    field = '0;
    for (int c = 0; c < NCOLS; c++) field[NROWS*c +: NROWS] = col_q[c];
  end

  assign crash = crash_q;
  assign score = score_q;

endmodule
